// File: rtl/reg_writeback_unit_if.sv
// Handshake and write-port bundle between the result producers, the control
// unit and the register-file writeback front end.
interface reg_writeback_unit_if;
  logic        ALU_Valid;
  logic [2:0]  ALU_DR;
  logic [15:0] ALU_Data;
  logic        ALU_Ready;
  logic        MEM_Valid;
  logic [2:0]  MEM_DR;
  logic [15:0] MEM_Data;
  logic        MEM_Ready;
  logic        WB_En;
  logic        LD_REG;
  logic [2:0]  DR;
  logic [15:0] Out;
  logic [2:0]  NZP;
  logic [7:0]  Busy;

  modport master (
    output ALU_Valid, ALU_DR, ALU_Data,
    output MEM_Valid, MEM_DR, MEM_Data,
    output WB_En,
    input  ALU_Ready, MEM_Ready,
    input  LD_REG, DR, Out, NZP, Busy
  );

  modport slave (
    input  ALU_Valid, ALU_DR, ALU_Data,
    input  MEM_Valid, MEM_DR, MEM_Data,
    input  WB_En,
    output ALU_Ready, MEM_Ready,
    output LD_REG, DR, Out, NZP, Busy
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Register-file write front end: ALU/MEM arbitration, in-order FIFO, NZP and
// per-register pending scoreboard. Define REG_WB_BYPASS_EN for empty-FIFO bypass.
module reg_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input logic                 Clk,
  input logic                 Reset,
  reg_writeback_unit_if.slave wb
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]      q_dr   [DEPTH];
  logic [15:0]     q_data [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            rr;
  logic [CNTW-1:0] cnt     [8];
  logic [CNTW-1:0] cnt_nxt [8];

  logic        empty;
  logic        fifo_ld;
  logic        space;
  logic        contested;
  logic        grant_alu;
  logic        grant_mem;
  logic        byp;
  logic        enq;
  logic [2:0]  in_dr;
  logic [15:0] in_data;
  logic [2:0]  head_dr;
  logic [15:0] head_data;
  logic        ld_w;
  logic [2:0]  dr_w;
  logic [15:0] out_w;
  logic [7:0]  busy_w;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    empty     = (count == '0);
    fifo_ld   = wb.WB_En && !empty;
    // Grants are held off while reset is asserted so Ready reads low then.
    space     = Reset && ((count < CW'(DEPTH)) || fifo_ld);
    contested = space && wb.ALU_Valid && wb.MEM_Valid;
    grant_mem = space && wb.MEM_Valid && (!wb.ALU_Valid || !rr);
    grant_alu = space && wb.ALU_Valid && (!wb.MEM_Valid || rr);
    in_dr     = grant_alu ? wb.ALU_DR   : wb.MEM_DR;
    in_data   = grant_alu ? wb.ALU_Data : wb.MEM_Data;
`ifdef REG_WB_BYPASS_EN
    byp       = empty && wb.WB_En && (grant_alu || grant_mem);
`else
    byp       = 1'b0;
`endif
    enq       = (grant_alu || grant_mem) && !byp;
    head_dr   = q_dr[rd_ptr];
    head_data = q_data[rd_ptr];
  end

  always_comb begin
    ld_w  = fifo_ld || byp;
    dr_w  = 3'd0;
    out_w = 16'h0000;
    if (byp) begin
      dr_w  = in_dr;
      out_w = in_data;
    end else if (!empty) begin
      dr_w  = head_dr;
      out_w = head_data;
    end
  end

  always_comb begin
    wb.ALU_Ready = grant_alu;
    wb.MEM_Ready = grant_mem;
    wb.LD_REG    = ld_w;
    wb.DR        = dr_w;
    wb.Out       = out_w;
    wb.NZP       = 3'b000;
    if (ld_w) begin
      wb.NZP = {out_w[15], (out_w == 16'h0000), (!out_w[15] && (out_w != 16'h0000))};
    end
    wb.Busy = busy_w;
  end

  // Same-cycle accept and retire of one register cancel out.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      cnt_nxt[r] = cnt[r];
      if ((enq && (in_dr == 3'(r))) && !(fifo_ld && (head_dr == 3'(r)))) begin
        cnt_nxt[r] = cnt[r] + 1'b1;
      end else if (!(enq && (in_dr == 3'(r))) && (fifo_ld && (head_dr == 3'(r)))) begin
        cnt_nxt[r] = cnt[r] - 1'b1;
      end
      busy_w[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rr     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_dr[i]   <= 3'd0;
        q_data[i] <= 16'h0000;
      end
      for (int r = 0; r < 8; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      if (enq) begin
        q_dr[wr_ptr]   <= in_dr;
        q_data[wr_ptr] <= in_data;
        wr_ptr         <= ptr_next(wr_ptr);
      end
      if (fifo_ld) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (enq && !fifo_ld) begin
        count <= count + 1'b1;
      end else if (!enq && fifo_ld) begin
        count <= count - 1'b1;
      end
      if (contested) begin
        rr <= ~rr;
      end
      for (int r = 0; r < 8; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed vector bench for reg_writeback_unit (DEPTH=4).
module tb_reg_writeback_unit;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  reg_writeback_unit_if bus ();

  reg_writeback_unit #(.DEPTH(4)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .wb    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        av;
    logic [2:0]  adr;
    logic [15:0] adat;
    logic        mv;
    logic [2:0]  mdr;
    logic [15:0] mdat;
    logic        we;
    logic        e_ar;
    logic        e_mr;
    logic        e_ld;
    logic [2:0]  e_dr;
    logic [15:0] e_out;
    logic [2:0]  e_nzp;
    logic [7:0]  e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic av, input logic [2:0] adr, input logic [15:0] adat,
    input logic mv, input logic [2:0] mdr, input logic [15:0] mdat,
    input logic we, input logic e_ar, input logic e_mr, input logic e_ld,
    input logic [2:0] e_dr, input logic [15:0] e_out, input logic [2:0] e_nzp,
    input logic [7:0] e_busy);
    vec_t v;
    v.av = av; v.adr = adr; v.adat = adat;
    v.mv = mv; v.mdr = mdr; v.mdat = mdat;
    v.we = we; v.e_ar = e_ar; v.e_mr = e_mr; v.e_ld = e_ld;
    v.e_dr = e_dr; v.e_out = e_out; v.e_nzp = e_nzp; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] adr, input logic [15:0] adat,
                       input logic mv, input logic [2:0] mdr, input logic [15:0] mdat,
                       input logic we);
    bus.ALU_Valid = av; bus.ALU_DR = adr; bus.ALU_Data = adat;
    bus.MEM_Valid = mv; bus.MEM_DR = mdr; bus.MEM_Data = mdat;
    bus.WB_En     = we;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ld"},   16'(bus.LD_REG), 16'h0);
    chk({tag, " dr"},   16'(bus.DR),     16'h0);
    chk({tag, " out"},  bus.Out,         16'h0);
    chk({tag, " nzp"},  16'(bus.NZP),    16'h0);
    chk({tag, " busy"}, 16'(bus.Busy),   16'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // ---- reset values
    #3;
    chk_idle("reset");
    chk("reset alu_rdy", 16'(bus.ALU_Ready), 16'h0);
    chk("reset mem_rdy", 16'(bus.MEM_Ready), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single write R3 <= 8001 with WB_En high
    @(negedge clk);
    drive(1, 3'd3, 16'h8001, 0, 0, 0, 1);
    #1;
    chk("sw alu_rdy", 16'(bus.ALU_Ready), 16'h1);
`ifdef REG_WB_BYPASS_EN
    chk("sw byp ld",  16'(bus.LD_REG), 16'h1);
    chk("sw byp dr",  16'(bus.DR),     16'h3);
    chk("sw byp out", bus.Out,         16'h8001);
    chk("sw byp nzp", 16'(bus.NZP),    16'h4);
    chk("sw byp busy", 16'(bus.Busy),  16'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk_idle("sw after");
`else
    chk("sw ld0",   16'(bus.LD_REG), 16'h0);
    chk("sw busy0", 16'(bus.Busy),   16'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("sw ld",   16'(bus.LD_REG), 16'h1);
    chk("sw dr",   16'(bus.DR),     16'h3);
    chk("sw out",  bus.Out,         16'h8001);
    chk("sw nzp",  16'(bus.NZP),    16'h4);
    chk("sw busy", 16'(bus.Busy),   16'h08);
    @(negedge clk);
    #1;
    chk_idle("sw after");
`endif

    // ---- table: contention + drain, backpressure, same-register ordering
    //            av adr   adat      mv mdr  mdat     we ar mr ld dr    out       nzp     busy
    tbl.push_back(mk(1, 3'd1, 16'h0001, 1, 3'd2, 16'h0002, 0, 0, 1, 0, 3'd0, 16'h0000, 3'b000, 8'h00));
    tbl.push_back(mk(1, 3'd1, 16'h0001, 1, 3'd2, 16'h0002, 0, 1, 0, 0, 3'd2, 16'h0002, 3'b000, 8'h04));
    tbl.push_back(mk(1, 3'd1, 16'h0001, 1, 3'd2, 16'h0002, 0, 0, 1, 0, 3'd2, 16'h0002, 3'b000, 8'h06));
    tbl.push_back(mk(1, 3'd1, 16'h0001, 1, 3'd2, 16'h0002, 0, 1, 0, 0, 3'd2, 16'h0002, 3'b000, 8'h06));
    tbl.push_back(mk(1, 3'd1, 16'h0001, 1, 3'd2, 16'h0002, 0, 0, 0, 0, 3'd2, 16'h0002, 3'b000, 8'h06));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd2, 16'h0002, 3'b001, 8'h06));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd1, 16'h0001, 3'b001, 8'h06));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd2, 16'h0002, 3'b001, 8'h06));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd1, 16'h0001, 3'b001, 8'h02));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 0, 3'd0, 16'h0000, 3'b000, 8'h00));
    tbl.push_back(mk(1, 3'd1, 16'hFFFF, 0, 3'd0, 16'h0000, 0, 1, 0, 0, 3'd0, 16'h0000, 3'b000, 8'h00));
    tbl.push_back(mk(1, 3'd2, 16'h0000, 0, 3'd0, 16'h0000, 0, 1, 0, 0, 3'd1, 16'hFFFF, 3'b000, 8'h02));
    tbl.push_back(mk(1, 3'd3, 16'h1234, 0, 3'd0, 16'h0000, 0, 1, 0, 0, 3'd1, 16'hFFFF, 3'b000, 8'h06));
    tbl.push_back(mk(1, 3'd4, 16'h8000, 0, 3'd0, 16'h0000, 0, 1, 0, 0, 3'd1, 16'hFFFF, 3'b000, 8'h0E));
    tbl.push_back(mk(1, 3'd5, 16'h0042, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 3'd1, 16'hFFFF, 3'b000, 8'h1E));
    tbl.push_back(mk(1, 3'd5, 16'h0042, 0, 3'd0, 16'h0000, 1, 1, 0, 1, 3'd1, 16'hFFFF, 3'b100, 8'h1E));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd2, 16'h0000, 3'b010, 8'h3C));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd3, 16'h1234, 3'b001, 8'h38));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd4, 16'h8000, 3'b100, 8'h30));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd5, 16'h0042, 3'b001, 8'h20));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 0, 3'd0, 16'h0000, 3'b000, 8'h00));
    tbl.push_back(mk(1, 3'd2, 16'h0000, 0, 3'd0, 16'h0000, 0, 1, 0, 0, 3'd0, 16'h0000, 3'b000, 8'h00));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 1, 3'd2, 16'h0005, 0, 0, 1, 0, 3'd2, 16'h0000, 3'b000, 8'h04));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 3'd2, 16'h0000, 3'b000, 8'h04));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd2, 16'h0000, 3'b010, 8'h04));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 1, 3'd2, 16'h0005, 3'b001, 8'h04));
    tbl.push_back(mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 0, 0, 3'd0, 16'h0000, 3'b000, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].adr, tbl[i].adat, tbl[i].mv, tbl[i].mdr, tbl[i].mdat, tbl[i].we);
      #1;
      chk($sformatf("v%0d alu_rdy", i), 16'(bus.ALU_Ready), 16'(tbl[i].e_ar));
      chk($sformatf("v%0d mem_rdy", i), 16'(bus.MEM_Ready), 16'(tbl[i].e_mr));
      chk($sformatf("v%0d ld", i),      16'(bus.LD_REG),    16'(tbl[i].e_ld));
      chk($sformatf("v%0d dr", i),      16'(bus.DR),        16'(tbl[i].e_dr));
      chk($sformatf("v%0d out", i),     bus.Out,            tbl[i].e_out);
      chk($sformatf("v%0d busy", i),    16'(bus.Busy),      16'(tbl[i].e_busy));
      if (tbl[i].e_ld || (tbl[i].e_busy == 8'h00))
        chk($sformatf("v%0d nzp", i),   16'(bus.NZP),       16'(tbl[i].e_nzp));
    end

    // ---- reset with three entries queued and rr pointing at ALU
    @(negedge clk);
    drive(1, 3'd1, 16'h0101, 1, 3'd2, 16'h0202, 0);
    #1;
    chk("rm mem_rdy", 16'(bus.MEM_Ready), 16'h1);
    chk("rm alu_rdy", 16'(bus.ALU_Ready), 16'h0);
    @(negedge clk);
    drive(1, 3'd1, 16'h0101, 0, 0, 0, 0);
    #1;
    chk("rm alu_rdy2", 16'(bus.ALU_Ready), 16'h1);
    @(negedge clk);
    drive(0, 0, 0, 1, 3'd4, 16'h0404, 0);
    #1;
    chk("rm mem_rdy3", 16'(bus.MEM_Ready), 16'h1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rm busy q", 16'(bus.Busy), 16'h16);
    chk("rm dr q",   16'(bus.DR),   16'h2);
    chk("rm out q",  bus.Out,       16'h0202);
    #1;
    rst_n = 1'b0;
    bus.ALU_Valid = 1'b1;
    #1;
    chk_idle("rm in reset");
    chk("rm rst alu_rdy", 16'(bus.ALU_Ready), 16'h0);
    bus.WB_En = 1'b1;
    #1;
    chk("rm rst ld we", 16'(bus.LD_REG), 16'h0);
    @(negedge clk);
    chk_idle("rm held");
    drive(0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rm post%0d ld", c),   16'(bus.LD_REG), 16'h0);
      chk($sformatf("rm post%0d busy", c), 16'(bus.Busy),   16'h0);
    end
    @(negedge clk);
    drive(1, 3'd6, 16'h0006, 1, 3'd7, 16'h0007, 0);
    #1;
    chk("rm rr mem_rdy", 16'(bus.MEM_Ready), 16'h1);
    chk("rm rr alu_rdy", 16'(bus.ALU_Ready), 16'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_writeback_unit.md
# reg_writeback_unit

Write-side front end for the 8×16 general-purpose register file. Accepts result writes from two producers, the ALU path and the memory-load path, through valid/ready handshakes. Queues them in a shared in-order FIFO and drives the register file's write port (LD_REG, DR, data) whenever the control unit enables writeback. Also computes the LC-3 NZP condition codes for each write and publishes a per-register pending-write scoreboard for hazard detection.

## Interface
- DEPTH, 4, FIFO entries (2..8)
- CNTW, $clog2(DEPTH+1), width of each per-register pending counter
- Clk  input  1  system clock, rising edge
- Reset  input  1  reset, asynchronous, active-low
- ALU_Valid  input  1  ALU result offered
- ALU_DR  input  3  ALU destination register
- ALU_Data  input  16  ALU result
- ALU_Ready  output  1  ALU result accepted this cycle
- MEM_Valid  input  1  load data offered
- MEM_DR  input  3  load destination register
- MEM_Data  input  16  load data
- MEM_Ready  output  1  load data accepted this cycle
- WB_En  input  1  control unit permits a register write this cycle
- LD_REG  output  1  register-file load strobe
- DR  output  3  register-file destination select
- Out  output  16  register-file write data
- NZP  output  3  condition codes of Out, {N,Z,P}; meaningful only when LD_REG=1
- Busy  output  8  Busy[r]=1 while any accepted write to Rr has not retired

## Operation
- Transfer on a source when Valid&&Ready at the rising edge. At most one source is accepted per cycle.
- Space: space = (count<DEPTH) || (LD_REG&&WB_En).
- Arbitration, both Valid and space: round-robin pointer rr (0=MEM, 1=ALU) picks the winner. rr flips to the loser after every contested grant.
- Uncontested grant: a single Valid source with space is granted, and rr is unchanged.
- Ready: high only for the granted source. Never asserted without its own Valid.
- FIFO: in-order. The head drives DR and Out combinationally. LD_REG = WB_En && !empty.
- Dequeue: on each edge with LD_REG=1. With space from a dequeue, enqueue and dequeue happen in the same cycle.
- Empty FIFO: DR=0, Out=0, NZP=0.
- NZP: N=Out[15]; Z=(Out==0); P=!N&&!Z. Exactly one bit is set whenever LD_REG=1.
- Scoreboard: one CNTW-bit counter per register.
  - Incremented on accept for its DR.
  - Decremented on retire (LD_REG at edge) for its DR.
  - Simultaneous increment and decrement of the same register leaves it unchanged.
  - Busy[r] = (cnt[r]!=0).
  - Multiple pending writes to the same register are legal. They retire in order, so the last accepted write wins.
- Reset asserted, including mid-operation: all entries are discarded, no write is issued, counters clear, and rr resets to 0.

## Timing
- Reset values: LD_REG=0, DR=0, Out=0, NZP=0, Busy=0, ALU_Ready=0, MEM_Ready=0.
- Latency without bypass:
  - A write accepted at edge k presents LD_REG in cycle k→k+1 if WB_En=1 and it is at the FIFO head.
  - The register file captures it at edge k+1.
- WB_En low: the head holds stable. DR and Out do not change and Busy stays set.
- Full FIFO with WB_En=0: both Ready signals are low, and sources must hold Valid/DR/Data until accepted.
- Busy rises the cycle after acceptance and falls the cycle after retirement.

## Configuration
- REG_WB_BYPASS_EN defined:
  - Applies when the FIFO is empty and WB_En=1.
  - The granted source's DR/Data drive DR/Out combinationally, with LD_REG=1 in the same cycle (0-cycle latency).
  - The entry is not enqueued and the scoreboard is not touched.
  - All other cases are unchanged.
- REG_WB_BYPASS_EN undefined: every write passes through the FIFO, giving a minimum latency of 1 cycle and registered-only paths from sources to the write port.

## Test plan
- Single write, WB_En=1:
  - Stimulus: ALU_Valid, ALU_DR=3, ALU_Data=16'h8001 for one cycle.
  - Response, no bypass: next cycle LD_REG=1, DR=3, Out=16'h8001, NZP=3'b100; Busy[3] high for exactly that cycle.
  - Response, with bypass: LD_REG in the same cycle and Busy[3] stays 0.
- Contention:
  - Stimulus: ALU and MEM both Valid for 4 cycles (ALU_Data=1, MEM_Data=2).
  - Response: grants alternate MEM, ALU, MEM, ALU, and the retire order matches.
- Backpressure, DEPTH=4:
  - Stimulus: WB_En=0 while ALU streams writes to R1..R5.
  - Response: 4 accepted; ALU_Ready=0 on the 5th; Busy=8'b0001_1110.
  - Then raise WB_En: R1..R4 retire on consecutive cycles and R5 is accepted in the first dequeue cycle.
- Same-register ordering:
  - Stimulus: two writes to R2 (16'h0000, then 16'h0005) with WB_En=0.
  - Response: cnt[2]=2.
  - Then WB_En=1: retires 16'h0000 with NZP=010, then 16'h0005 with NZP=001; Busy[2] falls after the second retire.
- Reset mid-operation:
  - Stimulus: assert Reset with 3 entries queued.
  - Response: LD_REG=0, Busy=0, and outputs are zero immediately. After release, no stale entry is ever written.
